// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - 16-bit result to 8-digit multiplexed display feeder
// Hex passthrough or sequential double-dabble BCD, with leading-zero blanking in decimal.
module display_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        hex_mode,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  digit,
  output logic        hex_trigger,
  output logic [7:0]  AN
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t        state, state_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [15:0]   shift_reg, shift_next;
  logic [19:0]   bcd, bcd_next;
  logic [19:0]   disp_reg, disp_next;
  logic          shown_hex, shown_hex_next;
  logic [19:0]   adj;

  logic [PW-1:0] presc;
  logic [2:0]    scan_idx;
  logic [19:0]   sel;
  logic          en;
  logic [3:0]    digit_next;
  logic [7:0]    an_next;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift_reg <= 16'd0;
      bcd       <= 20'd0;
      disp_reg  <= 20'd0;
      shown_hex <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      bcd       <= bcd_next;
      disp_reg  <= disp_next;
      shown_hex <= shown_hex_next;
    end
  end

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift_reg;
    bcd_next       = bcd;
    disp_next      = disp_reg;
    shown_hex_next = shown_hex;
    adj            = bcd;
    case (state)
      IDLE: begin
        if (load) begin
          if (hex_mode) begin
            disp_next      = {4'h0, value};
            shown_hex_next = 1'b1;
          end else begin
            shift_next   = value;
            bcd_next     = 20'd0;
            bit_cnt_next = 4'd0;
            state_next   = CONVERT;
          end
        end
      end
      CONVERT: begin
        // Adjust every BCD nibble before the shift so it carries correctly into the next digit.
        for (int i = 0; i < 5; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {bcd_next, shift_next} = {adj[18:0], shift_reg, 1'b0};
        bit_cnt_next = bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) state_next = DONE;
      end
      DONE: begin
        disp_next      = bcd;
        shown_hex_next = 1'b0;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc    <= '0;
      scan_idx <= 3'd0;
    end else if (presc == PRESC_LAST) begin
      presc    <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      presc    <= presc + PW'(1);
    end
  end

  // Everything above the selected nibble stays in sel, so |sel means "this or a higher digit is nonzero".
  always_comb begin
    sel        = disp_reg >> {scan_idx, 2'b00};
    digit_next = (scan_idx >= 3'd5) ? 4'd0 : sel[3:0];
    if (shown_hex) en = (scan_idx < 3'd4);
    else           en = (scan_idx == 3'd0) || ((scan_idx <= 3'd4) && (|sel));
    an_next    = en ? ~(8'b1 << scan_idx) : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit       <= 4'd0;
      hex_trigger <= 1'b0;
      AN          <= 8'hFF;
    end else begin
      digit       <= digit_next;
      hex_trigger <= shown_hex;
      AN          <= an_next;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - randomized self-checking bench for display_scan_driver
module tb_display_scan_driver;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] value;
  logic        hex_mode;
  logic        load;
  logic        busy;
  logic [3:0]  digit;
  logic        hex_trigger;
  logic [7:0]  AN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_val = 0;
  bit model_hex = 1'b0;

  display_scan_driver #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .hex_mode(hex_mode), .load(load),
    .busy(busy), .digit(digit), .hex_trigger(hex_trigger), .AN(AN)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r *= 10;
    return r;
  endfunction

  function automatic int exp_digit(input int k);
    if (k >= 5) return 0;
    if (model_hex) return (model_val >> (4 * k)) & 15;
    return (model_val / p10(k)) % 10;
  endfunction

  function automatic bit exp_en(input int k);
    if (model_hex) return k < 4;
    return (k == 0) || (k <= 4 && model_val >= p10(k));
  endfunction

  task automatic check_frame(input string tag, input int n);
    int k;
    logic [7:0] an_exp;
    for (int i = 0; i < n; i++) begin
      k = ((cyc - 1) / RD) % 8;
      an_exp = exp_en(k) ? ~(8'(1) << k) : 8'hFF;
      check({tag, "_digit"}, 32'(digit), 32'(exp_digit(k)));
      check({tag, "_an"}, 32'(AN), 32'(an_exp));
      check({tag, "_hex"}, 32'(hex_trigger), 32'(model_hex));
      @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic h);
    value = v; hex_mode = h; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("busy_timeout", 32'(busy), 32'(0));
  endtask

  task automatic bcd_load(input string tag, input logic [15:0] v);
    int n;
    do_load(v, 1'b0);
    wait_idle(n);
    check({tag, "_busy_len"}, 32'(n), 32'd17);
    model_val = int'(v); model_hex = 1'b0;
    repeat (3) @(negedge clk);
    check_frame(tag, 34);
  endtask

  task automatic hex_load(input string tag, input logic [15:0] v);
    do_load(v, 1'b1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    model_val = int'(v); model_hex = 1'b1;
    repeat (2) @(negedge clk);
    check_frame(tag, 34);
  endtask

  initial begin
    int n;
    logic [15:0] rv;
    reset_n = 1'b0; value = '0; hex_mode = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(AN), 32'hFF);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_hex", 32'(hex_trigger), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_frame("idle", 36);

    hex_load("beef", 16'hBEEF);
    bcd_load("max", 16'd65535);
    bcd_load("seven", 16'd7);

    do_load(16'd1234, 1'b0);
    repeat (3) @(negedge clk);
    do_load(16'h00FF, 1'b1);
    wait_idle(n);
    model_val = 1234; model_hex = 1'b0;
    repeat (3) @(negedge clk);
    check_frame("ignored", 34);

    do_load(16'd999, 1'b0);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an", 32'(AN), 32'hFF);
    reset_n = 1'b1;
    model_val = 0; model_hex = 1'b0;
    @(negedge clk);
    check_frame("abort", 34);

    for (int t = 0; t < 10; t++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rv = 16'($urandom_range(0, 120));
      if ($urandom_range(0, 1) == 1) hex_load("rnd_hex", rv);
      else                           bcd_load("rnd_bcd", rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
